remote_comm: RTL and testbench
==============================

// Module: remote_comm
// PURPOSE
//   Remote-side link partner of the command-receiving UART wrapper. Takes a 16-bit command, serialises it
//   over TX as two 8N1 frames (high byte first, then low byte), and receives the 8-bit response byte on RX.
//   Contains its own transmit serialiser, receive deserialiser and the two-byte sequencing FSM.
// PARAMETERS
//   BAUD_DIV  2604  clk cycles per UART bit (50 MHz / 19200 baud); legal range 16..65535
// PORTS
//   clk           in   1   system clock; all state updates on posedge
//   rst           in   1   synchronous, active-high reset
//   snd_cmd       in   1   request to send cmd; accepted only in IDLE
//   cmd           in   16  command word; sampled on the accepted snd_cmd cycle
//   clr_resp_rdy  in   1   clears resp_rdy
//   RX            in   1   serial input from the command-receiving wrapper (asynchronous)
//   TX            out  1   serial output to the command-receiving wrapper; idles high
//   cmd_snt       out  1   high once both bytes are sent; held until next accepted snd_cmd
//   resp_rdy      out  1   new response byte valid in resp
//   resp          out  8   last received response byte
// BEHAVIOUR
//   Reset: one clk edge with rst=1 gives TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, FSMs idle, counters 0.
//     Reset mid-frame aborts immediately; no partial byte is completed.
//   Sequencing FSM: IDLE -> TX_HI -> TX_LO -> IDLE.
//     IDLE: snd_cmd=1 latches cmd into a 16-bit shadow register, clears cmd_snt and resp_rdy, starts the high-byte frame.
//     TX_HI: when the high frame's stop bit completes, starts the low-byte frame on the same edge (no idle gap).
//     TX_LO: when the stop bit completes, sets cmd_snt and returns to IDLE.
//     snd_cmd outside IDLE is ignored. cmd changes after acceptance have no effect.
//   TX timing: if snd_cmd is sampled at edge 0, TX=0 (start bit) from edge 1.
//     Each bit lasts exactly BAUD_DIV cycles.
//     Frame is start(0), data[0]..data[7] LSB first, stop(1).
//     The low frame starts at edge 1+10*BAUD_DIV. cmd_snt=1 from edge 1+20*BAUD_DIV. TX is registered (glitch-free).
//   RX path:
//     RX passes through a 2-flop synchroniser preset to 1 by rst. A falling edge on the synchronised RX in RX_IDLE starts reception.
//     Start bit is re-sampled after BAUD_DIV/2 cycles; if it reads 1 (glitch), return to RX_IDLE.
//     Otherwise the 8 data bits and the stop bit are sampled at BAUD_DIV intervals (bit centres).
//     Stop=1: resp <= byte and resp_rdy <= 1 on the stop-bit sample edge.
//     Stop=0 (framing error): byte discarded; resp and resp_rdy unchanged.
//     The receiver then returns to RX_IDLE and rearms on the next falling edge.
//   RX runs independently of the TX FSM; full duplex is allowed.
//   resp_rdy priority: set (byte completes) > clear (clr_resp_rdy or accepted snd_cmd) > hold.
//   Counters: baud counter 16 bits, bit counter 4 bits; both reload on every frame start, with no wrap across frames.
// TESTING  (BAUD_DIV=16 unless noted)
//   1. rst=1 for 2 cycles mid high-byte frame -> next edge TX=1, cmd_snt=0, resp_rdy=0, resp=00; no further TX activity.
//   2. snd_cmd with cmd=16'hA55A at edge 0 -> from edge 1, TX bits every 16 cycles:
//      0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1; cmd_snt=1 at edge 321, not before.
//   3. snd_cmd pulses and a cmd change to 16'hFFFF during TX_LO -> ignored; waveform still matches 16'hA55A.
//      A new snd_cmd after cmd_snt clears cmd_snt on the next edge.
//   4. Bench drives 8N1 byte 8'h3C on RX at 16 cycles/bit -> resp=3C, resp_rdy=1 at the stop-bit mid-sample.
//      clr_resp_rdy -> resp_rdy=0 next edge.
//   5. Edge cases:
//      - 4-cycle low glitch on RX -> no reception, resp_rdy stays 0.
//      - Byte 8'h81 with stop bit 0 -> discarded; resp unchanged.
//   6. clr_resp_rdy asserted on the same edge a byte 8'h5E completes -> resp_rdy=1, resp=5E.
//      Simultaneous TX of cmd and RX of a response gives both correct results.

Source files
------------

// File: rtl/remote_comm.sv
// Remote link partner: sends a 16-bit command as two 8N1 frames (high byte first)
// and receives 8N1 response bytes on RX, independently of the transmit side.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   r_tx_state;
  logic [15:0] r_shadow;
  logic [15:0] r_tx_baud;
  logic [3:0]  r_tx_bit;
  logic        r_tx;
  logic        r_cmd_snt;
  logic        w_accept;
  logic [9:0]  w_tx_frame;

  assign w_accept   = (r_tx_state == IDLE) && snd_cmd;
  assign w_tx_frame = (r_tx_state == TX_HI) ? {1'b1, r_shadow[15:8], 1'b0}
                                            : {1'b1, r_shadow[7:0], 1'b0};

  // r_tx_bit is the index of the next frame bit to drive; index 10 means the
  // stop bit has just finished, which lets the low frame start with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_shadow   <= '0;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_cmd_snt  <= 1'b0;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (snd_cmd) begin
            r_shadow   <= cmd;
            r_cmd_snt  <= 1'b0;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TX_HI;
          end
        end
        TX_HI, TX_LO: begin
          if (r_tx_baud != '0) begin
            r_tx_baud <= r_tx_baud - 16'd1;
          end else if (r_tx_bit != 4'd10) begin
            r_tx      <= w_tx_frame[r_tx_bit];
            r_tx_bit  <= r_tx_bit + 4'd1;
            r_tx_baud <= BAUD_LAST;
          end else if (r_tx_state == TX_HI) begin
            r_tx       <= 1'b0;
            r_tx_bit   <= 4'd1;
            r_tx_baud  <= BAUD_LAST;
            r_tx_state <= TX_LO;
          end else begin
            r_cmd_snt  <= 1'b1;
            r_tx_bit   <= '0;
            r_tx_state <= IDLE;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  rx_state_t   r_rx_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [15:0] r_rx_baud;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_byte;
  logic [7:0]  r_resp;
  logic        r_resp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_resp     <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_rx_s1   <= RX;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      // The set in RX_STOP comes later in this block so it wins over a clear.
      if (clr_resp_rdy || w_accept)
        r_resp_rdy <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_baud  <= BAUD_HALF;
            r_rx_bit   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_baud != '0) begin
            r_rx_baud <= r_rx_baud - 16'd1;
          end else if (r_rx_s2) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_baud  <= BAUD_LAST;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_baud != '0) begin
            r_rx_baud <= r_rx_baud - 16'd1;
          end else begin
            r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
            r_rx_baud <= BAUD_LAST;
            if (r_rx_bit == 4'd7)
              r_rx_state <= RX_STOP;
            else
              r_rx_bit <= r_rx_bit + 4'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_baud != '0) begin
            r_rx_baud <= r_rx_baud - 16'd1;
          end else begin
            if (r_rx_s2) begin
              r_resp     <= r_rx_byte;
              r_resp_rdy <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign TX       = r_tx;
  assign cmd_snt  = r_cmd_snt;
  assign resp     = r_resp;
  assign resp_rdy = r_resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at 16 clocks per bit: command framing, RX
// reception, glitch/framing rejection, resp_rdy priority and mid-frame reset.
module tb_remote_comm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;

  // TX bit k of the 20-bit sequence sits at vector index k (time order)
  logic [19:0] exp_a55a = 20'b1010110100_1101001010;
  logic [19:0] exp_1234 = 20'b1001101000_1000100100;

  logic       tx_hist  [0:321];
  logic       snt_hist [0:321];
  logic       rdy_hist [0:160];
  logic [7:0] resp_hist[0:160];

  remote_comm #(.BAUD_DIV(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .snd_cmd      (snd_cmd),
    .cmd          (cmd),
    .clr_resp_rdy (clr_resp_rdy),
    .RX           (RX),
    .TX           (TX),
    .cmd_snt      (cmd_snt),
    .resp_rdy     (resp_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  // Issues snd_cmd at edge 0 and records TX/cmd_snt after edges 1..321.
  task automatic tx_capture(input logic [15:0] c, input logic inject);
    cmd = c;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    for (int n = 1; n <= 321; n++) begin
      if (inject && n == 200) begin
        snd_cmd = 1'b1;
        cmd = 16'hFFFF;
      end
      if (inject && n == 204) snd_cmd = 1'b0;
      @(posedge clk); #1;
      tx_hist[n]  = TX;
      snt_hist[n] = cmd_snt;
    end
  endtask

  // Drives one 8N1 frame on RX from edge E0, clr_resp_rdy high for edges
  // clr_from..clr_to (relative), recording resp_rdy/resp after edges 1..160.
  task automatic rx_frame(input logic [7:0] b, input logic stopv,
                          input int clr_from, input int clr_to);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    @(posedge clk); #1;
    for (int c = 0; c < 160; c++) begin
      RX = fr[c / 16];
      clr_resp_rdy = (c + 1 >= clr_from) && (c + 1 <= clr_to);
      @(posedge clk); #1;
      rdy_hist[c + 1]  = resp_rdy;
      resp_hist[c + 1] = resp;
    end
    RX = 1'b1;
    clr_resp_rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
    checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL reset_cmd_snt got %b exp 0", cmd_snt); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h exp 00", resp); end
  endtask

  task automatic test_tx_frame;
    tx_capture(16'hA55A, 1'b0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (tx_hist[1 + 16 * k + 8] !== exp_a55a[k]) begin
        errors++;
        $display("FAIL tx_a55a_bit%0d got %b exp %b", k, tx_hist[1 + 16 * k + 8], exp_a55a[k]);
      end
    end
    checks++; if (tx_hist[1] !== 1'b0) begin errors++; $display("FAIL tx_start_edge1 got %b exp 0", tx_hist[1]); end
    checks++; if (tx_hist[161] !== 1'b0) begin errors++; $display("FAIL tx_lo_start_edge161 got %b exp 0", tx_hist[161]); end
    checks++; if (tx_hist[160] !== 1'b1) begin errors++; $display("FAIL tx_hi_stop_edge160 got %b exp 1", tx_hist[160]); end
    checks++; if (snt_hist[320] !== 1'b0) begin errors++; $display("FAIL cmd_snt_edge320 got %b exp 0", snt_hist[320]); end
    checks++; if (snt_hist[321] !== 1'b1) begin errors++; $display("FAIL cmd_snt_edge321 got %b exp 1", snt_hist[321]); end
  endtask

  task automatic test_ignore;
    tx_capture(16'hA55A, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (tx_hist[1 + 16 * k + 8] !== exp_a55a[k]) begin
        errors++;
        $display("FAIL ignore_bit%0d got %b exp %b", k, tx_hist[1 + 16 * k + 8], exp_a55a[k]);
      end
    end
    checks++; if (snt_hist[321] !== 1'b1) begin errors++; $display("FAIL ignore_cmd_snt got %b exp 1", snt_hist[321]); end
    cmd = 16'hA55A;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL resend_clears_cmd_snt got %b exp 0", cmd_snt); end
    repeat (330) @(posedge clk);
    #1;
    checks++; if (cmd_snt !== 1'b1) begin errors++; $display("FAIL resend_done got %b exp 1", cmd_snt); end
  endtask

  task automatic test_rx;
    rx_frame(8'h3C, 1'b1, 0, 0);
    checks++; if (rdy_hist[148] !== 1'b0) begin errors++; $display("FAIL rx_rdy_early got %b exp 0", rdy_hist[148]); end
    checks++; if (rdy_hist[158] !== 1'b1) begin errors++; $display("FAIL rx_rdy_set got %b exp 1", rdy_hist[158]); end
    checks++; if (resp !== 8'h3C) begin errors++; $display("FAIL rx_resp got %h exp 3c", resp); end
    clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    clr_resp_rdy = 1'b0;
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rx_clear got %b exp 0", resp_rdy); end
  endtask

  task automatic test_glitch;
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h3C) begin errors++; $display("FAIL glitch_resp got %h exp 3c", resp); end
  endtask

  task automatic test_framing;
    rx_frame(8'h81, 1'b0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL framing_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h3C) begin errors++; $display("FAIL framing_resp got %h exp 3c", resp); end
  endtask

  task automatic test_back_to_back;
    fork
      tx_capture(16'h1234, 1'b0);
      rx_frame(8'h5E, 1'b1, 153, 155);
    join
    checks++; if (rdy_hist[155] !== 1'b1) begin errors++; $display("FAIL collide_rdy got %b exp 1", rdy_hist[155]); end
    checks++; if (resp_hist[155] !== 8'h5E) begin errors++; $display("FAIL collide_resp got %h exp 5e", resp_hist[155]); end
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL collide_rdy_hold got %b exp 1", resp_rdy); end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (tx_hist[1 + 16 * k + 8] !== exp_1234[k]) begin
        errors++;
        $display("FAIL duplex_tx_bit%0d got %b exp %b", k, tx_hist[1 + 16 * k + 8], exp_1234[k]);
      end
    end
    checks++; if (snt_hist[321] !== 1'b1) begin errors++; $display("FAIL duplex_cmd_snt got %b exp 1", snt_hist[321]); end
  endtask

  task automatic test_reset_midframe;
    int lows;
    cmd = 16'hA55A;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL midframe_tx_before got %b exp 0", TX); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", TX); end
    checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL midrst_cmd_snt got %b exp 0", cmd_snt); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL midrst_resp_rdy got %b exp 0", resp_rdy); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL midrst_resp got %h exp 00", resp); end
    lows = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (TX !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL midrst_tx_quiet got %0d low cycles exp 0", lows); end
    checks++; if (cmd_snt !== 1'b0) begin errors++; $display("FAIL midrst_no_cmd_snt got %b exp 0", cmd_snt); end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_ignore;
    test_rx;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
